output_buffer_writer: RTL and testbench



---
 rtl/output_buffer_pkg.sv | 30 +++
 rtl/output_buffer_writer_pos.sv | 75 +++++++
 rtl/output_buffer_writer.sv | 136 +++++++++++++
 tb/tb_output_buffer_writer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/output_buffer_pkg.sv
// Shared definitions for the 3x3 output buffer and its write-side companion.
// Holds the writer FSM state encoding and the padded-frame geometry helpers
// so that the buffer and the writer derive DEPTH/PAD_* identically.
package output_buffer_pkg;

  // Writer sequencing states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } wr_state_t;

  // One-pixel zero border on each side
  function automatic int unsigned pad_dim(input int unsigned n);
    return n + 32'd2;
  endfunction

  // Element count of the zero-padded frame
  function automatic int unsigned buf_depth(input int unsigned in_width,
                                            input int unsigned in_height,
                                            input int unsigned channels);
    return pad_dim(in_width) * pad_dim(in_height) * channels;
  endfunction

  // Counter width that stays at least one bit for single-value ranges
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/output_buffer_writer_pos.sv
// padded_pos_counter: walks the padded frame in row / col / channel order
// (channel innermost) alongside a linear address equal to the write count.
// Ports:
//   clk, rst_n  clock and async active-low reset
//   clear       zero all counters (takes priority over advance)
//   advance     step to the next position; wraps to 0 after the last one
//   addr        linear address of the current position
//   border_c    current position lies on the zero border (combinational)
//   last_c      current position is the final one of the frame (combinational)
module padded_pos_counter
  import output_buffer_pkg::*;
#(
  parameter int unsigned PAD_WIDTH  = 7,
  parameter int unsigned PAD_HEIGHT = 7,
  parameter int unsigned CHANNELS   = 3,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  advance,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  border_c,
  output logic                  last_c
);

  localparam int unsigned DEPTH = PAD_WIDTH * PAD_HEIGHT * CHANNELS;
  localparam int unsigned ROW_W = cnt_width(PAD_HEIGHT);
  localparam int unsigned COL_W = cnt_width(PAD_WIDTH);
  localparam int unsigned CH_W  = cnt_width(CHANNELS);

  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic [CH_W-1:0]  ch;

  logic row_end_c;
  logic col_end_c;
  logic ch_end_c;

  assign row_end_c = (row == ROW_W'(PAD_HEIGHT - 1));
  assign col_end_c = (col == COL_W'(PAD_WIDTH - 1));
  assign ch_end_c  = (ch == CH_W'(CHANNELS - 1));

  assign border_c = (row == '0) || row_end_c || (col == '0) || col_end_c;
  assign last_c   = (addr == ADDR_WIDTH'(DEPTH - 1));

  // Nested counters plus linear address, all stepping on the same advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row  <= '0;
      col  <= '0;
      ch   <= '0;
      addr <= '0;
    end else if (clear) begin
      row  <= '0;
      col  <= '0;
      ch   <= '0;
      addr <= '0;
    end else if (advance) begin
      addr <= last_c ? '0 : addr + ADDR_WIDTH'(1);
      if (ch_end_c) begin
        ch <= '0;
        if (col_end_c) begin
          col <= '0;
          row <= row_end_c ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end else begin
        ch <= ch + CH_W'(1);
      end
    end
  end

endmodule

// File: rtl/output_buffer_writer.sv
// output_buffer_writer: turns an unpadded raster stream (channels innermost)
// into one buffer write per padded-frame position. Border positions write 0
// with is_padding set and consume nothing; interior positions wait for a
// stream beat. Optional build macro OUTBUF_WR_RELU_EN clamps negative
// interior data to zero.
// Ports:
//   clk, rst_n   clock and async active-low reset
//   start        begin a frame when idle (ignored while busy)
//   in_data      signed stream element
//   in_valid     stream element valid
//   in_ready     writer accepts in_data this cycle (combinational, state only)
//   wr_en        buffer write strobe (registered)
//   wr_addr      buffer write address (registered)
//   wr_data      buffer write data (registered)
//   is_padding   current write is a border zero (registered)
//   busy         frame in progress (registered)
//   done         one-cycle frame-complete pulse (registered)
module output_buffer_writer
  import output_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned OUT_CHANNELS   = 3,
  parameter int unsigned IN_WIDTH       = 5,
  parameter int unsigned IN_HEIGHT      = 5,
  localparam int unsigned PAD_WIDTH     = pad_dim(IN_WIDTH),
  localparam int unsigned PAD_HEIGHT    = pad_dim(IN_HEIGHT),
  localparam int unsigned DEPTH         = buf_depth(IN_WIDTH, IN_HEIGHT, OUT_CHANNELS),
  localparam int unsigned WR_ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     wr_en,
  output logic [WR_ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     is_padding,
  output logic                     busy,
  output logic                     done
);

  wr_state_t state;
  wr_state_t state_nxt;

  logic                     advance_c;
  logic                     clear_c;
  logic [WR_ADDR_WIDTH-1:0] pos_addr;
  logic                     border_c;
  logic                     last_c;
  logic [DATA_WIDTH-1:0]    interior_data_c;

  padded_pos_counter #(
    .PAD_WIDTH  (PAD_WIDTH),
    .PAD_HEIGHT (PAD_HEIGHT),
    .CHANNELS   (OUT_CHANNELS),
    .ADDR_WIDTH (WR_ADDR_WIDTH)
  ) u_pos (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear_c),
    .advance  (advance_c),
    .addr     (pos_addr),
    .border_c (border_c),
    .last_c   (last_c)
  );

  // Interior data path: optional ReLU on the signed element
`ifdef OUTBUF_WR_RELU_EN
  assign interior_data_c = in_data[DATA_WIDTH-1] ? '0 : in_data;
`else
  assign interior_data_c = in_data;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, handshake and position advance
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    advance_c = 1'b0;
    clear_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_RUN;
          clear_c   = 1'b1;
        end
      end
      ST_RUN: begin
        // Border positions resolve on their own; interior ones need a beat
        in_ready  = !border_c;
        advance_c = border_c || in_valid;
        if (advance_c && last_c) begin
          state_nxt = ST_FIN;
        end
      end
      ST_FIN: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Registered write port and status; done lands the cycle after the last write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      is_padding <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      wr_en      <= advance_c;
      is_padding <= advance_c && border_c;
      if (advance_c) begin
        wr_addr <= pos_addr;
        wr_data <= border_c ? '0 : interior_data_c;
      end
      busy <= (state_nxt != ST_IDLE);
      done <= (state == ST_FIN);
    end
  end

endmodule

// File: tb/tb_output_buffer_writer.sv
// Self-checking bench for output_buffer_writer: a 5x5x3 instance driven with
// directed and randomized streams against a padded-frame reference model,
// plus a 1x1x1 instance for the smallest geometry.
module tb_output_buffer_writer;

  localparam int unsigned DW     = 8;
  localparam int unsigned CH     = 3;
  localparam int unsigned IW     = 5;
  localparam int unsigned IH     = 5;
  localparam int unsigned PW     = IW + 2;
  localparam int unsigned PH     = IH + 2;
  localparam int unsigned DEPTH  = PW * PH * CH;
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned NBEATS = IW * IH * CH;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          start;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          is_padding;
  logic          busy;
  logic          done;

  logic          s_start;
  logic [DW-1:0] s_in_data;
  logic          s_in_valid;
  logic          s_in_ready;
  logic          s_wr_en;
  logic [3:0]    s_wr_addr;
  logic [DW-1:0] s_wr_data;
  logic          s_is_padding;
  logic          s_busy;
  logic          s_done;

  output_buffer_writer #(
    .DATA_WIDTH(DW), .OUT_CHANNELS(CH), .IN_WIDTH(IW), .IN_HEIGHT(IH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .is_padding(is_padding),
    .busy(busy), .done(done)
  );

  output_buffer_writer #(
    .DATA_WIDTH(DW), .OUT_CHANNELS(1), .IN_WIDTH(1), .IN_HEIGHT(1)
  ) dut_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .in_data(s_in_data),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .wr_en(s_wr_en),
    .wr_addr(s_wr_addr), .wr_data(s_wr_data), .is_padding(s_is_padding),
    .busy(s_busy), .done(s_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  logic [DW-1:0] stream [NBEATS];

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] v);
`ifdef OUTBUF_WR_RELU_EN
    if (v[DW-1]) return '0;
`endif
    return v;
  endfunction

  // Position n of the padded frame decoded by division, not by counters
  function automatic bit is_border(input int n);
    int r = n / int'(PW * CH);
    int c = (n / int'(CH)) % int'(PW);
    return (r == 0) || (r == int'(PH) - 1) || (c == 0) || (c == int'(PW) - 1);
  endfunction

  function automatic logic [DW-1:0] exp_data(input int n);
    int r = n / int'(PW * CH);
    int c = (n / int'(CH)) % int'(PW);
    int k;
    if (is_border(n)) return '0;
    k = ((r - 1) * int'(IW) + (c - 1)) * int'(CH) + n % int'(CH);
    return relu(stream[k]);
  endfunction

  // One frame on the main instance. stall_at: hold valid low 10 cycles at the
  // first interior position at/after that address; restart_at: pulse start
  // mid-frame; reset_at: assert rst_n at that address and abandon the frame.
  task automatic run_frame(input int stall_at, input bit rand_valid,
                           input int restart_at, input int reset_at);
    int n_writes   = 0;
    int beats      = 0;
    int after_last = -1;
    int stall_left = 0;
    bit stalled    = 1'b0;
    bit restarted  = 1'b0;
    bit exp_wr     = 1'b0;
    bit exp_rdy;
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      if (after_last >= 0) after_last++;
      check_val("wr_en", 32'(wr_en), 32'(exp_wr));
      if (wr_en) begin
        if (n_writes >= int'(DEPTH)) begin
          check_val("extra_write", 32'(wr_addr), 32'hFFFF_FFFF);
        end else begin
          check_val("wr_addr", 32'(wr_addr), 32'(n_writes));
          check_val("is_padding", 32'(is_padding), 32'(is_border(n_writes)));
          check_val("wr_data", 32'(wr_data), 32'(exp_data(n_writes)));
        end
        n_writes++;
        if (n_writes == int'(DEPTH)) after_last = 0;
      end
      exp_rdy = (n_writes < int'(DEPTH)) && !is_border(n_writes);
      check_val("done", 32'(done), 32'(after_last == 1));
      check_val("busy", 32'(busy), 32'(after_last < 1));
      check_val("in_ready", 32'(in_ready), 32'(exp_rdy));
      if (after_last == 2) break;

      if (reset_at >= 0 && n_writes == reset_at) begin
        rst_n = 1'b0;
        #1;
        check_val("rst_wr_en", 32'(wr_en), 32'd0);
        check_val("rst_wr_addr", 32'(wr_addr), 32'd0);
        check_val("rst_wr_data", 32'(wr_data), 32'd0);
        check_val("rst_is_padding", 32'(is_padding), 32'd0);
        check_val("rst_in_ready", 32'(in_ready), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        start    = 1'b0;
        in_valid = 1'b0;
        return;
      end

      start = 1'b0;
      if (restart_at >= 0 && n_writes == restart_at && !restarted) begin
        start     = 1'b1;
        restarted = 1'b1;
      end
      if (stall_at >= 0 && n_writes >= stall_at && exp_rdy && !stalled) begin
        stalled    = 1'b1;
        stall_left = 10;
      end
      if (stall_left > 0) begin
        in_valid = 1'b0;
        stall_left--;
      end else begin
        in_valid = rand_valid ? ($urandom_range(3) != 0) : 1'b1;
      end
      in_data = (in_valid && beats < int'(NBEATS)) ? stream[beats] : DW'($urandom);
      exp_wr  = (n_writes < int'(DEPTH)) && (!exp_rdy || in_valid);
      if (in_valid && exp_rdy) beats++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    check_val("frame_end_seen", 32'(after_last == 2), 32'd1);
    check_val("write_count", 32'(n_writes), 32'(DEPTH));
    check_val("beat_count", 32'(beats), 32'(NBEATS));
  endtask

  task automatic fill_random(input logic [DW-1:0] first);
    for (int i = 0; i < int'(NBEATS); i++) stream[i] = DW'($urandom);
    stream[0] = first;
  endtask

  initial begin
    int sw = 0;
    int sd = 0;
    int sb = 0;
    logic [DW-1:0] s_val;

    rst_n      = 1'b0;
    start      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    s_start    = 1'b0;
    s_in_valid = 1'b0;
    s_in_data  = '0;
    repeat (3) @(negedge clk);
    check_val("reset_wr_en", 32'(wr_en), 32'd0);
    check_val("reset_wr_addr", 32'(wr_addr), 32'd0);
    check_val("reset_busy", 32'(busy), 32'd0);
    check_val("reset_done", 32'(done), 32'd0);
    check_val("reset_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_val("idle_in_ready", 32'(in_ready), 32'd0);

    // Directed ramp 0..74, valid always high
    for (int i = 0; i < int'(NBEATS); i++) stream[i] = DW'(i);
    run_frame(-1, 1'b0, -1, -1);
    // Same ramp with a 10-cycle stall
    run_frame(60, 1'b0, -1, -1);
    // Negative first element (ReLU-sensitive), random valid gaps
    fill_random(8'hF0);
    run_frame(-1, 1'b1, -1, -1);
    // Start pulsed mid-frame must be ignored
    fill_random(DW'($urandom));
    run_frame(-1, 1'b1, 50, -1);
    // Reset mid-frame, then a fresh frame from address 0
    fill_random(DW'($urandom));
    run_frame(-1, 1'b0, -1, 80);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill_random(DW'($urandom));
    run_frame(-1, 1'b1, -1, -1);

    // 1x1x1 geometry: 9 writes, address 4 the only interior one
    s_val      = DW'($urandom) | 8'h80;
    s_in_data  = s_val;
    s_in_valid = 1'b1;
    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (s_wr_en) begin
        check_val("s_wr_addr", 32'(s_wr_addr), 32'(sw));
        check_val("s_is_padding", 32'(s_is_padding), 32'(sw != 4));
        check_val("s_wr_data", 32'(s_wr_data), (sw == 4) ? 32'(relu(s_val)) : 32'd0);
        sw++;
      end
      if (s_done) sd++;
      if (s_in_valid && s_in_ready) sb++;
      @(negedge clk);
    end
    check_val("s_write_count", 32'(sw), 32'd9);
    check_val("s_done_count", 32'(sd), 32'd1);
    check_val("s_beat_count", 32'(sb), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
